sipo_frame_controller: RTL and testbench

Sequencing controller for a serial-in/parallel-out deserializer register of width `WIDTH`. It accepts a frame request of N words and gates the register's shift enable from a per-bit valid strobe. It counts bits and pulses the register's load at each word boundary. Completed words are presented through a valid/ready handshake with a last-word marker, and overruns are flagged. It sits between the serial link front-end and the word-consuming logic.

---
 rtl/sipo_frame_controller_if.sv | 28 ++
 rtl/sipo_frame_controller.sv | 163 ++++++++++++++++
 tb/tb_sipo_frame_controller.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sipo_frame_controller_if.sv
// rtl/sipo_frame_controller_if.sv - frame request, serial strobe, SIPO control and word handshake bundle
interface sipo_frame_controller_if #(
  parameter int WORDS_W = 8
);
  logic               start;
  logic [WORDS_W-1:0] frame_words;
  logic               bit_valid;
  logic               sipo_enable;
  logic               sipo_load;
  logic               word_valid;
  logic               word_ready;
  logic               word_last;
  logic               busy;
  logic               overrun;
  logic               timeout;

  // Controller side
  modport master (
    input  start, frame_words, bit_valid, word_ready,
    output sipo_enable, sipo_load, word_valid, word_last, busy, overrun, timeout
  );

  // Link front-end / word consumer side
  modport slave (
    output start, frame_words, bit_valid, word_ready,
    input  sipo_enable, sipo_load, word_valid, word_last, busy, overrun, timeout
  );
endinterface

// File: rtl/sipo_frame_controller.sv
// rtl/sipo_frame_controller.sv - SIPO deserializer sequencer; idle abort enabled by SIPO_CTRL_TIMEOUT_EN
module sipo_frame_controller #(
  parameter int WIDTH   = 8,
  parameter int WORDS_W = 8,
  parameter int TIMEOUT = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  sipo_frame_controller_if.master ctrl_if
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_LOAD  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [WORDS_W-1:0] words_left_q, words_left_d;
  logic               word_valid_q, word_valid_d;
  logic               word_last_q, word_last_d;
  logic               overrun_q, overrun_d;
  logic               sipo_enable;
  logic               sipo_load;
  logic               slot_free;

`ifdef SIPO_CTRL_TIMEOUT_EN
  localparam int IDLE_W = $clog2(TIMEOUT + 1);
  logic [IDLE_W-1:0]  idle_cnt_q, idle_cnt_d;
  logic               timeout_q, timeout_d;
`endif

  // The output register is free if empty or being drained this cycle
  assign slot_free = !word_valid_q || ctrl_if.word_ready;

  // Next-state, counters and SIPO strobes
  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    words_left_d = words_left_q;
    word_valid_d = word_valid_q && !ctrl_if.word_ready;
    word_last_d  = word_last_q;
    overrun_d    = overrun_q;
    sipo_enable  = 1'b0;
    sipo_load    = 1'b0;
`ifdef SIPO_CTRL_TIMEOUT_EN
    idle_cnt_d   = idle_cnt_q;
    timeout_d    = timeout_q;
`endif

    unique case (state_q)
      ST_IDLE: begin
        if (ctrl_if.start) begin
          state_d      = ST_SHIFT;
          bit_cnt_d    = '0;
          words_left_d = (ctrl_if.frame_words == '0) ? WORDS_W'(1) : ctrl_if.frame_words;
          overrun_d    = 1'b0;
`ifdef SIPO_CTRL_TIMEOUT_EN
          idle_cnt_d   = '0;
          timeout_d    = 1'b0;
`endif
        end
      end

      ST_SHIFT: begin
        sipo_enable = ctrl_if.bit_valid;
        if (ctrl_if.bit_valid) begin
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
          if (bit_cnt_q == CNT_W'(WIDTH - 1)) begin
            state_d = ST_LOAD;
          end
        end
`ifdef SIPO_CTRL_TIMEOUT_EN
        if (ctrl_if.bit_valid) begin
          idle_cnt_d = '0;
        end else if (idle_cnt_q == IDLE_W'(TIMEOUT - 1)) begin
          // Abandon the partial word; words already presented stay valid
          state_d    = ST_IDLE;
          bit_cnt_d  = '0;
          idle_cnt_d = '0;
          timeout_d  = 1'b1;
        end else begin
          idle_cnt_d = idle_cnt_q + IDLE_W'(1);
        end
`endif
      end

      ST_LOAD: begin
`ifdef SIPO_CTRL_TIMEOUT_EN
        idle_cnt_d = '0;
`endif
        if (slot_free) begin
          sipo_load    = 1'b1;
          word_valid_d = 1'b1;
          word_last_d  = (words_left_q == WORDS_W'(1));
          words_left_d = words_left_q - WORDS_W'(1);
          if (words_left_q == WORDS_W'(1)) begin
            state_d   = ST_IDLE;
            bit_cnt_d = '0;
          end else begin
            // SIPO loads its pre-shift contents, so shifting now loses nothing
            state_d     = ST_SHIFT;
            sipo_enable = ctrl_if.bit_valid;
            bit_cnt_d   = ctrl_if.bit_valid ? CNT_W'(1) : CNT_W'(0);
          end
        end else if (ctrl_if.bit_valid) begin
          overrun_d = 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and sticky flag registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      bit_cnt_q    <= '0;
      words_left_q <= '0;
      word_valid_q <= 1'b0;
      word_last_q  <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      words_left_q <= words_left_d;
      word_valid_q <= word_valid_d;
      word_last_q  <= word_last_d;
      overrun_q    <= overrun_d;
    end
  end

`ifdef SIPO_CTRL_TIMEOUT_EN
  // Idle-cycle counter and timeout flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      idle_cnt_q <= idle_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  assign ctrl_if.timeout = timeout_q;
`else
  assign ctrl_if.timeout = 1'b0;
`endif

  assign ctrl_if.sipo_enable = sipo_enable;
  assign ctrl_if.sipo_load   = sipo_load;
  assign ctrl_if.word_valid  = word_valid_q;
  assign ctrl_if.word_last   = word_last_q;
  assign ctrl_if.busy        = (state_q != ST_IDLE);
  assign ctrl_if.overrun     = overrun_q;

endmodule

// File: tb/tb_sipo_frame_controller.sv
// tb/tb_sipo_frame_controller.sv - scoreboard bench for sipo_frame_controller with a behavioural SIPO
module tb_sipo_frame_controller;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
  } word_t;

  logic       clk;
  logic       rst_n;
  logic       serial;
  logic       exp_en;
  logic [7:0] sr;
  logic [7:0] par;
  int         rel;
  int         checks;
  int         errors;
  int         exp_load_q[$];
  word_t      exp_word_q[$];

  sipo_frame_controller_if #(.WORDS_W(8)) bus ();

  sipo_frame_controller #(
    .WIDTH   (8),
    .WORDS_W (8),
    .TIMEOUT (16)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ctrl_if (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural SIPO: MSB-first shift, parallel register captures pre-shift contents
  always @(posedge clk) begin
    if (bus.sipo_load) par <= sr;
    if (bus.sipo_enable) sr <= {sr[6:0], serial};
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (frame cycle %0d)", name, act, exp, rel);
    end
  endtask

  // Monitor: compares strobes and accepted words against the scoreboard queues
  always @(negedge clk) begin
    word_t w;
    int    c;
    chk("sipo_enable", 32'(bus.sipo_enable), 32'(exp_en));
    if (bus.sipo_load) begin
      if (exp_load_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_load: got load at frame cycle %0d expected none", rel);
      end else begin
        c = exp_load_q.pop_front();
        chk("load_cycle", 32'(rel), 32'(c));
      end
    end
    if (bus.word_valid && bus.word_ready) begin
      if (exp_word_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_word: got %0h expected none", par);
      end else begin
        w = exp_word_q.pop_front();
        chk("word_data", 32'(par), 32'(w.data));
        chk("word_last", 32'(bus.word_last), 32'(w.last));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    rel++;
  endtask

  task automatic start_frame(input logic [7:0] fw);
    rel             = 0;
    bus.start       = 1'b1;
    bus.frame_words = fw;
    bus.bit_valid   = 1'b0;
    exp_en          = 1'b0;
    tick();
    bus.start       = 1'b0;
  endtask

  task automatic send_bits(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      bus.bit_valid = 1'b1;
      serial        = b[i];
      exp_en        = 1'b1;
      tick();
    end
    bus.bit_valid = 1'b0;
    exp_en        = 1'b0;
  endtask

  initial begin
    logic [7:0] b;
    checks          = 0;
    errors          = 0;
    rel             = 0;
    rst_n           = 1'b0;
    serial          = 1'b0;
    exp_en          = 1'b0;
    bus.start       = 1'b0;
    bus.frame_words = '0;
    bus.bit_valid   = 1'b0;
    bus.word_ready  = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_word_valid", 32'(bus.word_valid), 0);
    chk("rst_word_last", 32'(bus.word_last), 0);
    chk("rst_overrun", 32'(bus.overrun), 0);
    chk("rst_timeout", 32'(bus.timeout), 0);
    chk("rst_load", 32'(bus.sipo_load), 0);
    rst_n = 1'b1;
    tick();

    // Single word 0xB2
    start_frame(8'd1);
    exp_load_q.push_back(9);
    exp_word_q.push_back('{data: 8'hB2, last: 1'b1});
    send_bits(8'hB2);
    tick();
    chk("single_busy_c10", 32'(bus.busy), 0);
    chk("single_valid_c10", 32'(bus.word_valid), 1);
    chk("single_last_c10", 32'(bus.word_last), 1);
    tick();
    tick();

    // Streaming three words
    start_frame(8'd3);
    exp_load_q.push_back(9);
    exp_load_q.push_back(17);
    exp_load_q.push_back(25);
    exp_word_q.push_back('{data: 8'hB2, last: 1'b0});
    exp_word_q.push_back('{data: 8'h5A, last: 1'b0});
    exp_word_q.push_back('{data: 8'hC3, last: 1'b1});
    send_bits(8'hB2);
    send_bits(8'h5A);
    send_bits(8'hC3);
    tick();
    tick();
    chk("stream_overrun", 32'(bus.overrun), 0);
    chk("stream_busy", 32'(bus.busy), 0);

    // Backpressure: second word stalls, extra bit in cycle 17 is dropped
    bus.word_ready = 1'b0;
    start_frame(8'd2);
    exp_load_q.push_back(9);
    exp_word_q.push_back('{data: 8'hA5, last: 1'b0});
    exp_word_q.push_back('{data: 8'h0F, last: 1'b1});
    send_bits(8'hA5);
    send_bits(8'h0F);
    bus.bit_valid = 1'b1;
    serial        = 1'b1;
    exp_en        = 1'b0;
    tick();
    bus.bit_valid = 1'b0;
    chk("bp_overrun_set", 32'(bus.overrun), 1);
    chk("bp_busy_stall", 32'(bus.busy), 1);
    tick();
    tick();
    exp_load_q.push_back(20);
    bus.word_ready = 1'b1;
    tick();
    tick();
    chk("bp_busy_done", 32'(bus.busy), 0);
    chk("bp_overrun_sticky", 32'(bus.overrun), 1);

    // Gapped bits, every third cycle; start clears overrun
    start_frame(8'd1);
    chk("start_clears_overrun", 32'(bus.overrun), 0);
    exp_load_q.push_back(23);
    exp_word_q.push_back('{data: 8'h3C, last: 1'b1});
    b = 8'h3C;
    for (int i = 7; i >= 0; i--) begin
      bus.bit_valid = 1'b1;
      serial        = b[i];
      exp_en        = 1'b1;
      tick();
      bus.bit_valid = 1'b0;
      exp_en        = 1'b0;
      if (i > 0) begin
        tick();
        tick();
      end
    end
    tick();
    // Bits in IDLE must not shift
    bus.bit_valid = 1'b1;
    repeat (3) tick();
    bus.bit_valid = 1'b0;
    chk("idle_bits_busy", 32'(bus.busy), 0);

    // Pending word in IDLE, then reset mid-frame
    bus.word_ready = 1'b0;
    start_frame(8'd1);
    exp_load_q.push_back(9);
    send_bits(8'hFF);
    tick();
    tick();
    chk("pend_valid_idle", 32'(bus.word_valid), 1);
    chk("pend_last_idle", 32'(bus.word_last), 1);
    chk("pend_busy_idle", 32'(bus.busy), 0);
    start_frame(8'd2);
    for (int i = 0; i < 5; i++) begin
      bus.bit_valid = 1'b1;
      serial        = 1'b0;
      exp_en        = 1'b1;
      tick();
    end
    exp_en = 1'b0;
    rst_n  = 1'b0;
    #1;
    chk("midrst_busy", 32'(bus.busy), 0);
    chk("midrst_valid", 32'(bus.word_valid), 0);
    chk("midrst_last", 32'(bus.word_last), 0);
    chk("midrst_enable", 32'(bus.sipo_enable), 0);
    chk("midrst_load", 32'(bus.sipo_load), 0);
    tick();
    rst_n          = 1'b1;
    bus.bit_valid  = 1'b0;
    bus.word_ready = 1'b1;
    tick();

    // start while busy is ignored
    start_frame(8'd1);
    exp_load_q.push_back(9);
    exp_word_q.push_back('{data: 8'h66, last: 1'b1});
    b = 8'h66;
    for (int i = 7; i >= 0; i--) begin
      bus.bit_valid   = 1'b1;
      serial          = b[i];
      exp_en          = 1'b1;
      bus.start       = (rel == 3);
      bus.frame_words = (rel == 3) ? 8'd5 : 8'd1;
      tick();
    end
    bus.start     = 1'b0;
    bus.bit_valid = 1'b0;
    exp_en        = 1'b0;
    tick();
    chk("ignored_start_busy", 32'(bus.busy), 0);

    // frame_words = 0 behaves as one word
    start_frame(8'd0);
    exp_load_q.push_back(9);
    exp_word_q.push_back('{data: 8'h99, last: 1'b1});
    send_bits(8'h99);
    tick();
    chk("zero_words_busy", 32'(bus.busy), 0);
    tick();

    // Idle abort after 3 bits and 16 empty cycles
    start_frame(8'd1);
    for (int i = 0; i < 3; i++) begin
      bus.bit_valid = 1'b1;
      serial        = 1'b1;
      exp_en        = 1'b1;
      tick();
    end
    bus.bit_valid = 1'b0;
    exp_en        = 1'b0;
    repeat (15) tick();
    chk("to_busy_c19", 32'(bus.busy), 1);
    tick();
`ifdef SIPO_CTRL_TIMEOUT_EN
    chk("to_timeout", 32'(bus.timeout), 1);
    chk("to_busy", 32'(bus.busy), 0);
`else
    chk("to_timeout", 32'(bus.timeout), 0);
    chk("to_busy", 32'(bus.busy), 1);
`endif
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    repeat (3) tick();

    chk("loads_drained", 32'(exp_load_q.size()), 0);
    chk("words_drained", 32'(exp_word_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
